// File: rtl/hyperram_controller_if.sv
// Request/response bus between a client and hyperram_controller.
// One request is presented with valid_i and held until ready_o pulses;
// data_o carries read data and is valid together with ready_o.
//   valid_i    : request strobe
//   wren_i     : 1 = write, 0 = read
//   regspace_i : 1 = register space, 0 = memory space
//   addr_i     : byte address (bit 0 ignored)
//   data_i     : write data
//   sel_i      : byte enables for memory writes
//   ready_o    : one-cycle completion pulse
//   data_o     : read data
interface hyperram_controller_if;
    logic        valid_i;
    logic        wren_i;
    logic        regspace_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        ready_o;
    logic [31:0] data_o;

    modport master (
        output valid_i, wren_i, regspace_i, addr_i, data_i, sel_i,
        input  ready_o, data_o
    );

    modport slave (
        input  valid_i, wren_i, regspace_i, addr_i, data_i, sel_i,
        output ready_o, data_o
    );
endinterface

// File: rtl/hyperram_controller.sv
// Single-clock HyperBus master: executes one 32-bit memory or register
// access per bus request, one HyperBus byte per clk_i cycle.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-low reset
//   bus (slave)           : request/response bus (valid/ready)
//   tpre_i/tpost_i/tcsh_i : CS# setup, hold and minimum high time (cycles)
//   tacc_i                : initial latency in hb_ck cycles
//   trmax_i               : read timeout in units of 4 cycles, 0 = off
//   fixed_latency_i, double_latency_i : latency mode
//   hb_dq_i, hb_rwds_i    : HyperBus inputs
//   hb_*_o, hb_*_oe       : HyperBus outputs and output enables (registered)
module hyperram_controller (
    input  logic                  clk_i,
    input  logic                  rst_i,
    hyperram_controller_if.slave  bus,
    input  logic [3:0]            tpre_i,
    input  logic [3:0]            tpost_i,
    input  logic [3:0]            tcsh_i,
    input  logic [3:0]            tacc_i,
    input  logic [4:0]            trmax_i,
    input  logic                  fixed_latency_i,
    input  logic                  double_latency_i,
    input  logic [7:0]            hb_dq_i,
    input  logic                  hb_rwds_i,
    output logic                  hb_csn_o,
    output logic                  hb_ck_o,
    output logic                  hb_reset_no,
    output logic [7:0]            hb_dq_o,
    output logic                  hb_dq_oe,
    output logic                  hb_rwds_o,
    output logic                  hb_rwds_oe
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_CA,
        ST_LAT,
        ST_DATA,
        ST_POST,
        ST_CSH
    } state_t;

    state_t      r_state, w_state_n;
    logic [7:0]  r_cnt, w_cnt_n;
    logic        r_fin, w_fin_n;
    logic        w_ready_n;

    logic        r_wren, r_regspace;
    logic [31:1] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_sel;
    logic [7:0]  r_lat_len;
    logic        r_rwds_prev;
    logic [2:0]  r_ncap;
    logic [31:0] r_rdata;

    logic        r_ready;
    logic [31:0] r_data_o;
    logic        r_csn, r_ck, r_reset_n, r_dq_oe, r_rwds, r_rwds_oe;
    logic [7:0]  r_dq;

    logic        w_csn_n, w_ck_n, w_dq_oe_n, w_rwds_n, w_rwds_oe_n;
    logic [7:0]  w_dq_n;
    logic [1:0]  w_lane;

    logic [47:0] w_ca;
    logic        w_regwr;
    logic [7:0]  w_pre_len, w_post_len, w_nbytes, w_lat_len;
    logic        w_dbl, w_capture, w_timeout, w_data_done;
    logic [2:0]  w_ncap_next;
    logic [1:0]  w_cap_lane;

    assign w_ca = {~r_wren, r_regspace, 1'b1, 1'b0, r_addr[31:4], 13'd0, r_addr[3:1]};
    assign w_regwr    = r_regspace & r_wren;
    assign w_pre_len  = (tpre_i  == 4'd0) ? 8'd1 : {4'd0, tpre_i};
    assign w_post_len = (tpost_i == 4'd0) ? 8'd1 : {4'd0, tpost_i};
    assign w_nbytes   = w_regwr ? 8'd2 : 8'd4;

    // Latency doubling comes from the device RWDS strobe unless fixed.
    assign w_dbl     = fixed_latency_i ? double_latency_i : hb_rwds_i;
    assign w_lat_len = w_dbl ? {2'b00, tacc_i, 2'b00} : {3'b000, tacc_i, 1'b0};

    // Read bytes are taken on every RWDS edge (both directions).
    assign w_capture   = (r_state == ST_DATA) && !r_wren && !r_fin &&
                         (r_ncap != 3'd4) && (hb_rwds_i != r_rwds_prev);
    assign w_ncap_next = r_ncap + {2'b00, w_capture};
    assign w_cap_lane  = {r_ncap[1], ~r_ncap[0]};
    assign w_timeout   = (trmax_i != 5'd0) &&
                         ((r_cnt + 8'd1) >= {1'b0, trmax_i, 2'b00});
    assign w_data_done = r_wren ? (r_cnt == (w_nbytes - 8'd1))
                                : ((w_ncap_next == 3'd4) || w_timeout);

    // Next-state logic
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 8'd1;
        w_fin_n   = r_fin;
        w_ready_n = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_n = '0;
                w_fin_n = 1'b0;
                if (bus.valid_i) w_state_n = ST_PRE;
            end
            ST_PRE: begin
                if ((r_cnt + 8'd1) >= w_pre_len) begin
                    w_state_n = ST_CA;
                    w_cnt_n   = '0;
                end
            end
            ST_CA: begin
                if (r_cnt == 8'd5) begin
                    w_state_n = (w_regwr || (w_lat_len == 8'd0)) ? ST_DATA : ST_LAT;
                    w_cnt_n   = '0;
                end
            end
            ST_LAT: begin
                if ((r_cnt + 8'd1) >= r_lat_len) begin
                    w_state_n = ST_DATA;
                    w_cnt_n   = '0;
                end
            end
            ST_DATA: begin
                // hb_ck must be low before POST: if the last data cycle left
                // it high, spend one more DATA cycle (r_fin) to bring it low.
                if (r_fin) begin
                    w_state_n = ST_POST;
                    w_cnt_n   = '0;
                end else if (w_data_done) begin
                    if (r_ck) begin
                        w_fin_n = 1'b1;
                    end else begin
                        w_state_n = ST_POST;
                        w_cnt_n   = '0;
                    end
                end
            end
            ST_POST: begin
                if ((r_cnt + 8'd1) >= w_post_len) begin
                    w_ready_n = 1'b1;
                    w_cnt_n   = '0;
                    w_state_n = (tcsh_i == 4'd0) ? ST_IDLE : ST_CSH;
                end
            end
            ST_CSH: begin
                if ((r_cnt + 8'd1) >= {4'd0, tcsh_i}) begin
                    w_state_n = ST_IDLE;
                    w_cnt_n   = '0;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    // Pin values for the coming cycle, derived from the next state so that
    // every output can be registered without a cycle of lag.
    always_comb begin
        w_csn_n     = 1'b1;
        w_ck_n      = 1'b0;
        w_dq_n      = '0;
        w_dq_oe_n   = 1'b0;
        w_rwds_n    = 1'b0;
        w_rwds_oe_n = 1'b0;
        w_lane      = {w_cnt_n[1], ~w_cnt_n[0]};
        unique case (w_state_n)
            ST_PRE, ST_POST: begin
                w_csn_n = 1'b0;
            end
            ST_CA: begin
                w_csn_n   = 1'b0;
                w_ck_n    = ~r_ck;
                w_dq_oe_n = 1'b1;
                case (w_cnt_n[2:0])
                    3'd0:    w_dq_n = w_ca[47:40];
                    3'd1:    w_dq_n = w_ca[39:32];
                    3'd2:    w_dq_n = w_ca[31:24];
                    3'd3:    w_dq_n = w_ca[23:16];
                    3'd4:    w_dq_n = w_ca[15:8];
                    default: w_dq_n = w_ca[7:0];
                endcase
            end
            ST_LAT: begin
                w_csn_n = 1'b0;
                w_ck_n  = ~r_ck;
            end
            ST_DATA: begin
                w_csn_n = 1'b0;
                w_ck_n  = ~r_ck;
                if (r_wren) begin
                    w_dq_oe_n = 1'b1;
                    w_dq_n    = r_wdata[{w_lane, 3'b000} +: 8];
                    if (!w_regwr) begin
                        w_rwds_oe_n = 1'b1;
                        w_rwds_n    = ~r_sel[w_lane];
                    end
                end
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_fin   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_fin   <= w_fin_n;
        end
    end

    // Request latches, read capture and registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wren      <= 1'b0;
            r_regspace  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_sel       <= '0;
            r_lat_len   <= '0;
            r_rwds_prev <= 1'b0;
            r_ncap      <= '0;
            r_rdata     <= '0;
            r_ready     <= 1'b0;
            r_data_o    <= '0;
            r_csn       <= 1'b1;
            r_ck        <= 1'b0;
            r_reset_n   <= 1'b0;
            r_dq        <= '0;
            r_dq_oe     <= 1'b0;
            r_rwds      <= 1'b0;
            r_rwds_oe   <= 1'b0;
        end else begin
            r_reset_n   <= 1'b1;
            r_rwds_prev <= hb_rwds_i;
            if (r_state == ST_IDLE && bus.valid_i) begin
                r_wren     <= bus.wren_i;
                r_regspace <= bus.regspace_i;
                r_addr     <= bus.addr_i[31:1];
                r_wdata    <= bus.data_i;
                r_sel      <= bus.sel_i;
                r_rdata    <= '0;
                r_ncap     <= '0;
            end
            if (r_state == ST_CA && r_cnt == 8'd5) r_lat_len <= w_lat_len;
            if (w_capture) begin
                r_rdata[{w_cap_lane, 3'b000} +: 8] <= hb_dq_i;
                r_ncap <= w_ncap_next;
            end
            r_ready <= w_ready_n;
            if (w_ready_n && !r_wren) r_data_o <= r_rdata;
            r_csn     <= w_csn_n;
            r_ck      <= w_ck_n;
            r_dq      <= w_dq_n;
            r_dq_oe   <= w_dq_oe_n;
            r_rwds    <= w_rwds_n;
            r_rwds_oe <= w_rwds_oe_n;
        end
    end

    assign bus.ready_o = r_ready;
    assign bus.data_o  = r_data_o;
    assign hb_csn_o    = r_csn;
    assign hb_ck_o     = r_ck;
    assign hb_reset_no = r_reset_n;
    assign hb_dq_o     = r_dq;
    assign hb_dq_oe    = r_dq_oe;
    assign hb_rwds_o   = r_rwds;
    assign hb_rwds_oe  = r_rwds_oe;

endmodule

// File: tb/tb_hyperram_controller.sv
// Directed testbench for hyperram_controller: drives requests over the bus
// interface, plays the HyperRAM side of read bursts, records the pin trace
// of each transaction and compares it with hand-computed values.
module tb_hyperram_controller;

    logic        clk;
    logic        rst_n;
    logic [3:0]  tpre, tpost, tcsh, tacc;
    logic [4:0]  trmax;
    logic        fixed_lat, double_lat;
    logic [7:0]  hb_dq_i;
    logic        hb_rwds_i;
    logic        hb_csn_o, hb_ck_o, hb_reset_no, hb_dq_oe, hb_rwds_o, hb_rwds_oe;
    logic [7:0]  hb_dq_o;

    hyperram_controller_if bus();

    hyperram_controller dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .bus              (bus),
        .tpre_i           (tpre),
        .tpost_i          (tpost),
        .tcsh_i           (tcsh),
        .tacc_i           (tacc),
        .trmax_i          (trmax),
        .fixed_latency_i  (fixed_lat),
        .double_latency_i (double_lat),
        .hb_dq_i          (hb_dq_i),
        .hb_rwds_i        (hb_rwds_i),
        .hb_csn_o         (hb_csn_o),
        .hb_ck_o          (hb_ck_o),
        .hb_reset_no      (hb_reset_no),
        .hb_dq_o          (hb_dq_o),
        .hb_dq_oe         (hb_dq_oe),
        .hb_rwds_o        (hb_rwds_o),
        .hb_rwds_oe       (hb_rwds_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [46:0] RST_VEC = {1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  tr_dq   [256];
    logic        tr_oe   [256];
    logic        tr_rw   [256];
    logic        tr_rwoe [256];
    logic        tr_ck   [256];
    int          tr_len;
    int          n_ready;
    int          post_low;
    logic [31:0] rd_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [46:0] out_vec();
        return {bus.ready_o, bus.data_o, hb_csn_o, hb_ck_o, hb_reset_no,
                hb_dq_o, hb_dq_oe, hb_rwds_o, hb_rwds_oe};
    endfunction

    function automatic int pre_len();
        return (tpre == 4'd0) ? 1 : int'(tpre);
    endfunction

    function automatic logic [47:0] ca_of(input int pre);
        return {tr_dq[pre], tr_dq[pre+1], tr_dq[pre+2],
                tr_dq[pre+3], tr_dq[pre+4], tr_dq[pre+5]};
    endfunction

    // Cycles with DQ released between the CA phase and the first write byte.
    function automatic int lat_of(input int pre);
        for (int p = pre + 6; p < tr_len; p++)
            if (tr_oe[p]) return p - (pre + 6);
        return -1;
    endfunction

    function automatic int rwoe_count();
        int n = 0;
        for (int p = 0; p < tr_len; p++)
            if (tr_rwoe[p]) n++;
        return n;
    endfunction

    task automatic set_req(input logic wr, input logic rs, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        bus.wren_i     = wr;
        bus.regspace_i = rs;
        bus.addr_i     = a;
        bus.data_i     = d;
        bus.sel_i      = s;
    endtask

    // Runs one transaction. rb holds read bytes in bus order (first byte in
    // bits 31:24); strobes start dly cycles after the expected latency.
    task automatic run_txn(input logic rwds_ca, input int lat, input logic [31:0] rb,
                           input int nstrobe, input int dly, input bit keep, input bit started);
        int p;
        int s;
        int j;
        int pre;
        bit got;
        pre      = pre_len();
        s        = pre + 6 + lat + dly;
        p        = 0;
        got      = 0;
        n_ready  = 0;
        post_low = 0;
        bus.valid_i = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            if (!(started && i == 0)) @(negedge clk);
            if (!hb_csn_o && p < 256) begin
                tr_dq[p]   = hb_dq_o;
                tr_oe[p]   = hb_dq_oe;
                tr_rw[p]   = hb_rwds_o;
                tr_rwoe[p] = hb_rwds_oe;
                tr_ck[p]   = hb_ck_o;
                hb_rwds_i  = (p <= pre + 5) ? rwds_ca : 1'b0;
                hb_dq_i    = 8'h00;
                if (p >= s && (p - s) < nstrobe) begin
                    j         = p - s;
                    hb_rwds_i = (j % 2 == 0);
                    hb_dq_i   = rb[31 - 8*j -: 8];
                end
                p++;
            end
            if (bus.ready_o) begin
                got     = 1;
                n_ready++;
                rd_data = bus.data_o;
            end
        end
        tr_len    = p;
        hb_rwds_i = 1'b0;
        hb_dq_i   = 8'h00;
        if (!got) check("txn_complete", 0, 1);
        if (!keep) begin
            bus.valid_i = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (bus.ready_o) n_ready++;
                if (!hb_csn_o) post_low++;
            end
        end
    endtask

    initial begin
        int gap;
        rst_n = 1'b0;
        tpre = 4'd1; tpost = 4'd1; tcsh = 4'd1; tacc = 4'd6; trmax = 5'd0;
        fixed_lat = 1'b0; double_lat = 1'b0;
        hb_dq_i = 8'h00; hb_rwds_i = 1'b0;
        bus.valid_i = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset
        repeat (2) @(negedge clk);
        check("reset_outputs", out_vec(), RST_VEC);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_no_release", hb_reset_no, 1'b1);
        repeat (3) @(negedge clk);
        check("idle_csn", hb_csn_o, 1'b1);

        // Memory write, full byte enables, tacc 6
        tacc = 4'd6;
        set_req(1'b1, 1'b0, 32'h0000_0126, 32'hAABB_CCDD, 4'hF);
        run_txn(1'b0, 12, 32'h0, 0, 0, 0, 0);
        check("wr1_csn_len", tr_len, 24);
        check("wr1_ca", ca_of(1), 48'h2000_0012_0003);
        check("wr1_lat", lat_of(1), 12);
        check("wr1_dq", {tr_dq[19], tr_dq[20], tr_dq[21], tr_dq[22]}, 32'hCCDD_AABB);
        check("wr1_rwds", {tr_rw[19], tr_rw[20], tr_rw[21], tr_rw[22]}, 4'b0000);
        check("wr1_rwds_oe", rwoe_count(), 4);
        check("wr1_ready_pulses", n_ready, 1);
        check("wr1_idle_after", post_low, 0);

        // Memory write, partial byte enables, device asks for double latency
        tacc = 4'd3;
        set_req(1'b1, 1'b0, 32'h0, 32'h1122_3344, 4'h5);
        run_txn(1'b1, 12, 32'h0, 0, 0, 0, 0);
        check("wr2_ca", ca_of(1), 48'h2000_0000_0000);
        check("wr2_lat", lat_of(1), 12);
        check("wr2_dq", {tr_dq[19], tr_dq[20], tr_dq[21], tr_dq[22]}, 32'h3344_1122);
        check("wr2_rwds", {tr_rw[19], tr_rw[20], tr_rw[21], tr_rw[22]}, 4'b1010);

        // Read, single latency
        set_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        run_txn(1'b0, 6, 32'h1122_3344, 4, 0, 0, 0);
        check("rd1_ca", ca_of(1), 48'hA000_0001_0000);
        check("rd1_ca47", tr_dq[1][7], 1'b1);
        check("rd1_csn_len", tr_len, 18);
        check("rd1_data", rd_data, 32'h3344_1122);
        check("rd1_dq_oe_data", tr_oe[13], 1'b0);

        // Read, RWDS high during CA -> double latency
        run_txn(1'b1, 12, 32'h5AA5_0FF0, 4, 0, 0, 0);
        check("rd2_csn_len", tr_len, 24);
        check("rd2_data", rd_data, 32'h0FF0_5AA5);

        // Read, fixed + double latency with RWDS low
        fixed_lat = 1'b1; double_lat = 1'b1; tacc = 4'd2;
        run_txn(1'b0, 8, 32'h0102_0304, 4, 0, 0, 0);
        check("rd3_csn_len", tr_len, 20);
        check("rd3_data", rd_data, 32'h0304_0102);

        // Read, fixed single latency ignores RWDS high
        double_lat = 1'b0;
        run_txn(1'b1, 4, 32'hDEAD_BEEF, 4, 0, 0, 0);
        check("rd4_csn_len", tr_len, 16);
        check("rd4_data", rd_data, 32'hBEEF_DEAD);
        fixed_lat = 1'b0;

        // Read with strobes one cycle late: odd clock count gets an extra cycle
        tacc = 4'd3;
        run_txn(1'b0, 6, 32'hC0FF_EE11, 4, 1, 0, 0);
        check("rd5_csn_len", tr_len, 20);
        check("rd5_data", rd_data, 32'hEE11_C0FF);
        check("rd5_ck_last_data", tr_ck[17], 1'b1);
        check("rd5_ck_extra", tr_ck[18], 1'b0);

        // Register write: no latency, two bytes, RWDS not driven
        tacc = 4'd6;
        set_req(1'b1, 1'b1, 32'h0, 32'h0000_8F1F, 4'hF);
        run_txn(1'b0, 0, 32'h0, 0, 0, 0, 0);
        check("regwr_ca", ca_of(1), 48'h6000_0000_0000);
        check("regwr_lat", lat_of(1), 0);
        check("regwr_dq", {tr_dq[7], tr_dq[8]}, 16'h8F1F);
        check("regwr_rwds_oe", rwoe_count(), 0);
        check("regwr_csn_len", tr_len, 10);
        check("data_o_hold", rd_data, 32'hEE11_C0FF);

        // Read timeout with no strobes
        tacc = 4'd3; trmax = 5'd2;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        run_txn(1'b0, 6, 32'h0, 0, 0, 0, 0);
        check("tmo_csn_len", tr_len, 22);
        check("tmo_data", rd_data, 32'h0);
        trmax = 5'd0;

        // Back-to-back with valid held high, tcsh 5
        tcsh = 4'd5; tpre = 4'd2; tpost = 4'd3; tacc = 4'd1;
        set_req(1'b1, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 4'hF);
        run_txn(1'b0, 2, 32'h0, 0, 0, 1, 0);
        check("b2b_wr_len", tr_len, 17);
        check("b2b_wr_ca", ca_of(2), 48'h2000_0004_0000);
        check("b2b_wr_dq", {tr_dq[10], tr_dq[11], tr_dq[12], tr_dq[13]}, 32'hF00D_CAFE);
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        gap = 1;
        for (int i = 0; i < 50 && hb_csn_o; i++) begin
            @(negedge clk);
            if (hb_csn_o) gap++;
        end
        check("b2b_csn_high", gap, 6);
        run_txn(1'b0, 2, 32'h1234_5678, 4, 0, 0, 1);
        check("b2b_rd_len", tr_len, 17);
        check("b2b_rd_data", rd_data, 32'h5678_1234);
        tcsh = 4'd1; tpre = 4'd1; tpost = 4'd1;

        // Reset in the middle of a transaction
        tacc = 4'd6;
        set_req(1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 4'hF);
        bus.valid_i = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_active", hb_csn_o, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", out_vec(), RST_VEC);
        bus.valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_ready  = 0;
        post_low = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ready_o) n_ready++;
            if (!hb_csn_o) post_low++;
        end
        check("mid_no_ready", n_ready, 0);
        check("mid_stays_idle", post_low, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
